ita_sync_fifo: RTL and testbench
================================

# ita_sync_fifo

Synchronous single-clock FIFO that buffers post-activation output rows in the ITA datapath. It sits between the FIFO write controller and the output handshake controller. It provides full/empty/usage status and an optional fall-through (first-word bypass) mode. One push port and one pop port; no internal clock gating.

## Interface
- Clock: one clock, `clk_i`. Reset: asynchronous, active-low, `rst_ni`.

Parameters:
- `FALL_THROUGH`, default 1'b0: 1 = a push into an empty FIFO is visible on `data_o` in the same cycle.
- `DATA_WIDTH`, default 32: word width in bits. ITA sets this to N*WI.
- `DEPTH`, default 8: number of entries. Must be ≥1; ITA sets this to FifoDepth.
- `ADDR_DEPTH`, derived, not overridable: `DEPTH>1 ? $clog2(DEPTH) : 1`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `flush_i` in 1: synchronous clear of all contents.
- `testmode_i` in 1: accepted and ignored (no clock gating).
- `full_o` out 1: FIFO holds DEPTH entries.
- `empty_o` out 1: no data available.
- `usage_o` out ADDR_DEPTH: entry count, truncated to ADDR_DEPTH bits.
- `data_i` in DATA_WIDTH: write data.
- `push_i` in 1: write request.
- `data_o` out DATA_WIDTH: head-of-queue data.
- `pop_i` in 1: read request; consumes the word shown on `data_o`.

## Operation
- State: storage array `mem[DEPTH]`, `read_ptr`, `write_ptr` (ADDR_DEPTH bits each), `status_cnt` (ADDR_DEPTH+1 bits).
- `full_o = (status_cnt == DEPTH)`.
- `empty_o = (status_cnt == 0) && !(FALL_THROUGH && push_i)`.
- `usage_o = status_cnt[ADDR_DEPTH-1:0]`. When DEPTH is a power of two and the FIFO is full, this reads 0; consumers must qualify it with `full_o`.
- `data_o = mem[read_ptr]`.
  - Exception: when FALL_THROUGH=1, `status_cnt==0` and `push_i`, `data_o = data_i`.
- Push:
  - A push with `!full_o` writes `mem[write_ptr]`, increments `write_ptr`, and increments `status_cnt`.
  - A push while full is silently dropped; no state changes.
- Pop:
  - A pop with `!empty_o` increments `read_ptr` and decrements `status_cnt`.
  - A pop while empty is ignored.
- Pointer wrap: a pointer wraps to 0 after DEPTH-1, including when DEPTH is not a power of two.
- Simultaneous push and pop, not full and not empty: both take effect and `status_cnt` is unchanged.
- Simultaneous push and pop while full: only the pop occurs, so the count decreases by 1.
- Fall-through bypass: FALL_THROUGH=1, count 0, push and pop together. The word is passed straight through. Pointers, count and memory are unchanged.
- `flush_i`: clears both pointers and the count at the next edge. It has priority over push and pop in that cycle. Memory contents need not be cleared.
- Memory is written only on an accepted push. Entries that are not written hold their value.

## Timing
- Reset values:
  - `read_ptr`, `write_ptr`, `status_cnt` = 0 and `mem` = all zeros.
  - Hence `empty_o`=1, `full_o`=0, `usage_o`=0, `data_o`=0.
- Reset asserted mid-operation discards all contents immediately and asynchronously.
- All status outputs are combinational from registered state; `empty_o` is also combinational from `push_i` when FALL_THROUGH=1.
- Write-to-read latency:
  - FALL_THROUGH=0: 1 cycle. A word pushed at edge k appears on `data_o` after edge k, if it is at the head.
  - FALL_THROUGH=1: 0 cycles into an empty FIFO.
- Throughput: one push and one pop per cycle.

## Configuration
- `ITA_FIFO_ASSERTIONS_EN`
  - Defined: simulation-only assertions are compiled in.
    - Elaboration error if DEPTH < 1.
    - Error on `push_i && full_o`.
    - Error on `pop_i && empty_o`.
    - All checks are disabled while `!rst_ni`.
  - Undefined: no assertion code. Functional behaviour is identical in both cases.

## Structure
- No shared-package typedefs are required. Width parameters are local.
- ITA instantiates the FIFO with `fifo_data_t` / `fifo_usage_t` and `FifoDepth` from `ita_package`; those stay in the package.
- Single flat module with no sub-modules. The storage array is an internal register array.

## Test plan
All scenarios use DATA_WIDTH=8 and DEPTH=4 unless stated.
- Reset, then idle -> `empty_o`=1, `full_o`=0, `usage_o`=0, `data_o`=8'h00.
- Push 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles -> `full_o`=1 and `usage_o`=0.
  - Then push 8'h55 -> dropped.
  - Four pops then return 11, 22, 33, 44, then `empty_o`=1.
- Fill to 2 entries, then push+pop together for 6 cycles -> `usage_o` stays 2, data stays in order, and pointers wrap correctly.
- Full FIFO with push+pop in the same cycle -> `usage_o`=3, and the pushed word is not stored.
- FALL_THROUGH=1, empty, push 8'hA5 -> `data_o`=8'hA5 and `empty_o`=0 in the same cycle.
  - With a pop in that cycle -> count stays 0.
- 3 entries, assert `flush_i` with `push_i` -> next cycle `empty_o`=1 and `usage_o`=0.
  - Then assert `rst_ni` low mid-fill -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ita_sync_fifo_pkg.sv
// Shared types and helpers for the ITA output-row FIFO.
// The optional ITA_FIFO_ASSERTIONS_EN macro only affects ita_sync_fifo.sv.
package ita_sync_fifo_pkg;

  // Operation applied to the FIFO state at the next clock edge.
  typedef enum logic [2:0] {
    FIFO_OP_IDLE     = 3'd0,
    FIFO_OP_PUSH     = 3'd1,
    FIFO_OP_POP      = 3'd2,
    FIFO_OP_PUSH_POP = 3'd3,
    FIFO_OP_BYPASS   = 3'd4,
    FIFO_OP_FLUSH    = 3'd5
  } fifo_op_e;

  // Pointer width; a single-entry FIFO still carries a 1-bit pointer.
  function automatic int unsigned fifo_addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ita_sync_fifo.sv
// Single-clock FIFO for post-activation output rows, with optional first-word fall-through.
// Define ITA_FIFO_ASSERTIONS_EN to compile in simulation-only protocol checks.
module ita_sync_fifo
  import ita_sync_fifo_pkg::*;
#(
  parameter logic        FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned ADDR_DEPTH  = fifo_addr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned CNT_W = ADDR_DEPTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
  logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
  logic [CNT_W-1:0]      status_cnt_q, status_cnt_d;
  logic                  mem_we;
  logic                  cnt_zero;
  logic                  bypass;
  logic                  push_ok;
  logic                  pop_ok;
  fifo_op_e              op;

  // No clock gating inside, so the test-mode strap has nothing to control.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
    return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + ADDR_DEPTH'(1);
  endfunction

  // Status and head-of-queue view.
  assign cnt_zero = (status_cnt_q == '0);
  assign bypass   = FALL_THROUGH && cnt_zero && push_i;
  assign full_o   = (status_cnt_q == CNT_W'(DEPTH));
  assign empty_o  = cnt_zero && !(FALL_THROUGH && push_i);
  assign usage_o  = status_cnt_q[ADDR_DEPTH-1:0];
  assign data_o   = bypass ? data_i : mem_q[read_ptr_q];

  assign push_ok  = push_i && !full_o;
  assign pop_ok   = pop_i && !empty_o;

  // Decode this cycle's request; flush wins, a bypassed word never touches storage.
  always_comb begin
    op = FIFO_OP_IDLE;
    if (flush_i) begin
      op = FIFO_OP_FLUSH;
    end else if (bypass && pop_i) begin
      op = FIFO_OP_BYPASS;
    end else if (push_ok && pop_ok) begin
      op = FIFO_OP_PUSH_POP;
    end else if (push_ok) begin
      op = FIFO_OP_PUSH;
    end else if (pop_ok) begin
      op = FIFO_OP_POP;
    end
  end

  // Next pointer/count state and memory write enable.
  always_comb begin
    read_ptr_d   = read_ptr_q;
    write_ptr_d  = write_ptr_q;
    status_cnt_d = status_cnt_q;
    mem_we       = 1'b0;
    case (op)
      FIFO_OP_FLUSH: begin
        read_ptr_d   = '0;
        write_ptr_d  = '0;
        status_cnt_d = '0;
      end
      FIFO_OP_PUSH: begin
        mem_we       = 1'b1;
        write_ptr_d  = ptr_inc(write_ptr_q);
        status_cnt_d = status_cnt_q + CNT_W'(1);
      end
      FIFO_OP_POP: begin
        read_ptr_d   = ptr_inc(read_ptr_q);
        status_cnt_d = status_cnt_q - CNT_W'(1);
      end
      FIFO_OP_PUSH_POP: begin
        mem_we       = 1'b1;
        write_ptr_d  = ptr_inc(write_ptr_q);
        read_ptr_d   = ptr_inc(read_ptr_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_ptr_q   <= '0;
      write_ptr_q  <= '0;
      status_cnt_q <= '0;
    end else begin
      read_ptr_q   <= read_ptr_d;
      write_ptr_q  <= write_ptr_d;
      status_cnt_q <= status_cnt_d;
    end
  end

  // Storage; entries change only on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[write_ptr_q] <= data_i;
    end
  end

`ifdef ITA_FIFO_ASSERTIONS_EN
  if (DEPTH == 0) begin : g_depth_chk
    $error("ita_sync_fifo: DEPTH must be at least 1");
  end

  push_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
    else $error("ita_sync_fifo: push while full");

  pop_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
    else $error("ita_sync_fifo: pop while empty");
`else
  // Protocol checks compiled out.
`endif

endmodule

// File: tb/tb_ita_sync_fifo.sv
// Directed bench for ita_sync_fifo: a standard instance and a fall-through instance,
// both DATA_WIDTH=8, DEPTH=4.
module tb_ita_sync_fifo;

  logic       clk_i;
  logic       rst_ni;

  logic       flush_a, push_a, pop_a, full_a, empty_a;
  logic [7:0] din_a, dout_a;
  logic [1:0] usage_a;

  logic       flush_b, push_b, pop_b, full_b, empty_b;
  logic [7:0] din_b, dout_b;
  logic [1:0] usage_b;

  int total;
  int bad;

  ita_sync_fifo #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (8),
    .DEPTH        (4)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_a),
    .testmode_i (1'b0),
    .full_o     (full_a),
    .empty_o    (empty_a),
    .usage_o    (usage_a),
    .data_i     (din_a),
    .push_i     (push_a),
    .data_o     (dout_a),
    .pop_i      (pop_a)
  );

  ita_sync_fifo #(
    .FALL_THROUGH (1'b1),
    .DATA_WIDTH   (8),
    .DEPTH        (4)
  ) u_dut_ft (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_b),
    .testmode_i (1'b1),
    .full_o     (full_b),
    .empty_o    (empty_b),
    .usage_o    (usage_b),
    .data_i     (din_b),
    .push_i     (push_b),
    .data_o     (dout_b),
    .pop_i      (pop_b)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q [4];
    total   = 0;
    bad     = 0;
    rst_ni  = 1'b0;
    flush_a = 1'b0; push_a = 1'b0; pop_a = 1'b0; din_a = 8'h00;
    flush_b = 1'b0; push_b = 1'b0; pop_b = 1'b0; din_b = 8'h00;
    #12;
    rst_ni = 1'b1;
    tick();

    // Reset / idle
    chk("rst_empty", 8'(empty_a), 8'd1);
    chk("rst_full",  8'(full_a),  8'd0);
    chk("rst_usage", 8'(usage_a), 8'd0);
    chk("rst_data",  dout_a,      8'h00);
    chk("rst_ft_empty", 8'(empty_b), 8'd1);

    // Fill 11..44
    push_a = 1'b1; din_a = 8'h11;
    tick();
    chk("push1_data",  dout_a,      8'h11);
    chk("push1_usage", 8'(usage_a), 8'd1);
    chk("push1_empty", 8'(empty_a), 8'd0);
    din_a = 8'h22; tick();
    din_a = 8'h33; tick();
    din_a = 8'h44; tick();
    push_a = 1'b0;
    chk("fill_full",  8'(full_a),  8'd1);
    chk("fill_usage", 8'(usage_a), 8'd0);
    chk("fill_head",  dout_a,      8'h11);

    // Push while full is dropped
    push_a = 1'b1; din_a = 8'h55;
    tick();
    push_a = 1'b0;
    chk("ovf_full", 8'(full_a), 8'd1);
    chk("ovf_head", dout_a,     8'h11);

    // Drain in order
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    pop_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain%0d", i), dout_a, exp_q[i]);
      tick();
    end
    pop_a = 1'b0;
    chk("drain_empty", 8'(empty_a), 8'd1);
    chk("drain_usage", 8'(usage_a), 8'd0);

    // Pop while empty is ignored
    pop_a = 1'b1; tick(); pop_a = 1'b0;
    chk("udf_empty", 8'(empty_a), 8'd1);
    chk("udf_usage", 8'(usage_a), 8'd0);

    // Two entries, then 6 cycles of push+pop across the pointer wrap
    push_a = 1'b1; din_a = 8'h01; tick();
    din_a = 8'h02; tick();
    pop_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      din_a = 8'(k + 3);
      #1;
      chk($sformatf("pp_head%0d", k), dout_a, 8'(k + 1));
      tick();
      chk($sformatf("pp_usage%0d", k), 8'(usage_a), 8'd2);
    end
    pop_a = 1'b0; push_a = 1'b0;
    chk("pp_tail_head", dout_a, 8'h07);

    // Full plus simultaneous push and pop: only the pop happens
    push_a = 1'b1; din_a = 8'h09; tick();
    din_a = 8'h0A; tick();
    chk("full2_full", 8'(full_a), 8'd1);
    din_a = 8'hBB; pop_a = 1'b1;
    tick();
    push_a = 1'b0;
    chk("fpp_usage", 8'(usage_a), 8'd3);
    chk("fpp_full",  8'(full_a),  8'd0);
    exp_q = '{8'h08, 8'h09, 8'h0A, 8'h00};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("fpp_drain%0d", i), dout_a, exp_q[i]);
      tick();
    end
    pop_a = 1'b0;
    chk("fpp_empty", 8'(empty_a), 8'd1);

    // Flush beats a concurrent push
    push_a = 1'b1; din_a = 8'hC1; tick();
    din_a = 8'hC2; tick();
    din_a = 8'hC3; tick();
    chk("pre_flush_usage", 8'(usage_a), 8'd3);
    flush_a = 1'b1; din_a = 8'hC4;
    tick();
    flush_a = 1'b0; push_a = 1'b0;
    chk("flush_empty", 8'(empty_a), 8'd1);
    chk("flush_usage", 8'(usage_a), 8'd0);

    // Fall-through instance: bypass with pop leaves state untouched
    push_b = 1'b1; din_b = 8'hA5;
    #1;
    chk("ft_data",  dout_b,      8'hA5);
    chk("ft_empty", 8'(empty_b), 8'd0);
    pop_b = 1'b1;
    tick();
    push_b = 1'b0; pop_b = 1'b0;
    #1;
    chk("ft_bp_usage", 8'(usage_b), 8'd0);
    chk("ft_bp_empty", 8'(empty_b), 8'd1);
    chk("ft_bp_data",  dout_b,      8'h00);
    // Without a pop the bypassed word is stored
    push_b = 1'b1; din_b = 8'h5A;
    tick();
    push_b = 1'b0;
    #1;
    chk("ft_st_usage", 8'(usage_b), 8'd1);
    chk("ft_st_data",  dout_b,      8'h5A);
    chk("ft_st_empty", 8'(empty_b), 8'd0);

    // Asynchronous reset mid-fill
    push_a = 1'b1; din_a = 8'hD1; tick();
    din_a = 8'hD2; tick();
    chk("prerst_usage", 8'(usage_a), 8'd2);
    din_a = 8'hD3;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_empty", 8'(empty_a), 8'd1);
    chk("arst_full",  8'(full_a),  8'd0);
    chk("arst_usage", 8'(usage_a), 8'd0);
    chk("arst_data",  dout_a,      8'h00);
    chk("arst_ft_usage", 8'(usage_b), 8'd0);
    push_a = 1'b0;
    #3;
    rst_ni = 1'b1;
    tick();
    chk("post_rst_empty", 8'(empty_a), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
